// File: rtl/fragment_writer.sv
// fragment_writer: depth-tested read-modify-write of raster fragments to memory.
// Ports: clock/reset, fragment in (addr/color/depth/valid/done), stall/done out, Avalon-style master, counters.
module fragment_writer #(
  parameter int unsigned       ADDR_W       = 26,
  parameter logic [ADDR_W-1:0] DEPTH_OFFSET = 26'h0100000,
  parameter bit                DEPTH_TEST   = 1'b1,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [23:0]       color_in,
  input  logic [31:0]       depth_in,
  input  logic              in_valid,
  input  logic              done_in,
  output logic              stall_out,
  output logic              done_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  output logic [CNT_W-1:0]  frag_written,
  output logic [CNT_W-1:0]  frag_rejected
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_DEPTH,
    WR_COLOR
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       color_q;
  logic [31:0]       depth_q;
  logic              done_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  written_q;
  logic [CNT_W-1:0]  rejected_q;

  logic [ADDR_W-1:0] in_daddr;
  logic [ADDR_W-1:0] q_daddr;
  logic              depth_pass;

  // Depth word address; the sum truncates to ADDR_W so it wraps.
  assign in_daddr   = addr_in + DEPTH_OFFSET;
  assign q_daddr    = addr_q + DEPTH_OFFSET;
  // Strictly-less, signed: equal depth is rejected.
  assign depth_pass = $signed(depth_q) < $signed(mem_readdata);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      color_q    <= '0;
      depth_q    <= '0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
      written_q  <= '0;
      rejected_q <= '0;
    end else begin
      done_q <= done_in & (state_q == IDLE) & ~in_valid;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            addr_q  <= addr_in;
            color_q <= color_in;
            depth_q <= depth_in;
            maddr_q <= in_daddr;
            if (DEPTH_TEST) begin
              rd_q    <= 1'b1;
              state_q <= RD_REQ;
            end else begin
              wr_q    <= 1'b1;
              wdata_q <= depth_in;
              state_q <= WR_DEPTH;
            end
          end
        end
        RD_REQ: begin
          if (!mem_waitrequest) begin
            rd_q    <= 1'b0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_readdatavalid) begin
            if (depth_pass) begin
              wr_q    <= 1'b1;
              maddr_q <= q_daddr;
              wdata_q <= depth_q;
              state_q <= WR_DEPTH;
            end else begin
              rejected_q <= rejected_q + CNT_W'(1);
              state_q    <= IDLE;
            end
          end
        end
        WR_DEPTH: begin
          if (!mem_waitrequest) begin
            maddr_q <= addr_q;
            wdata_q <= {8'h00, color_q};
            state_q <= WR_COLOR;
          end
        end
        WR_COLOR: begin
          if (!mem_waitrequest) begin
            wr_q      <= 1'b0;
            written_q <= written_q + CNT_W'(1);
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_out     = (state_q != IDLE);
  assign done_out      = done_q;
  assign mem_address   = maddr_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_writedata = wdata_q;
  assign frag_written  = written_q;
  assign frag_rejected = rejected_q;

endmodule

// File: doc/fragment_writer.md
Name: fragment_writer

Overview:
- Consumer end of the rasterizer fragment stream: accepts (address, color, depth) fragments and performs a depth-buffer read-modify-write against frame memory over a single 32-bit memory-mapped master port.
- Applies backpressure upstream through stall_out, which connects to the rasterizer's stall_in.
- Forwards end-of-frame as done_out once the last fragment has fully retired to memory.

Parameters:
- ADDR_W, 26, width of fragment and memory word addresses.
- DEPTH_OFFSET, 26'h0100000, word offset from a color word to its depth word; modulo 2^ADDR_W, wraps.
- DEPTH_TEST, 1, 1 = write only if depth_in < stored depth (signed); 0 = always write, no depth read.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr_in  in  ADDR_W  color-buffer word address of the fragment.
- color_in  in  24  fragment RGB.
- depth_in  in  32  fragment depth, signed 16.16 fixed point.
- in_valid  in  1  fragment present on addr_in/color_in/depth_in.
- done_in  in  1  upstream finished the current triangle/frame (level).
- stall_out  out  1  fragment not accepted this cycle; upstream must hold it.
- done_out  out  1  done_in seen and no fragment in flight.
- mem_address  out  ADDR_W  memory word address.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_writedata  out  32  write data.
- mem_readdata  in  32  read return data.
- mem_readdatavalid  in  1  mem_readdata valid.
- mem_waitrequest  in  1  slave not accepting; hold request unchanged.
- frag_written  out  CNT_W  fragments written, wraps.
- frag_rejected  out  CNT_W  fragments failing depth test, wraps.

Behaviour:
- Reset (reset==0, async): state IDLE; stall_out=0, done_out=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, frag_written=0, frag_rejected=0, fragment registers cleared. Any in-flight request is abandoned; a read returning after reset is ignored.
- All outputs are registered or decoded only from registered state; no combinational path from inputs to outputs.
- stall_out = (state != IDLE).
- Accept: in IDLE with in_valid=1, capture addr/color/depth at the clock edge. Next state is RD_REQ (DEPTH_TEST=1) or WR_DEPTH (DEPTH_TEST=0).
- RD_REQ: mem_read=1, mem_address=addr+DEPTH_OFFSET. Hold while mem_waitrequest=1; on mem_waitrequest=0, go to RD_WAIT.
- RD_WAIT: no request. On mem_readdatavalid=1, compare signed depth < signed mem_readdata.
  - Pass: go to WR_DEPTH.
  - Fail (including equal): frag_rejected+1, go to IDLE.
  - mem_readdatavalid outside RD_WAIT is ignored.
- WR_DEPTH: mem_write=1, mem_address=addr+DEPTH_OFFSET, mem_writedata=depth. Hold until mem_waitrequest=0, then go to WR_COLOR.
- WR_COLOR: mem_write=1, mem_address=addr, mem_writedata={8'h00,color}. Hold until mem_waitrequest=0, then frag_written+1 and go to IDLE.
- Never mem_read and mem_write together. Address and data stay stable while mem_waitrequest=1.
- Minimum occupancy with zero wait states and readdatavalid one cycle after the read is accepted: 4 cycles with the depth test, 2 without. stall_out is high for exactly those cycles after the accept edge.
- A fragment can be accepted in the same cycle the previous one retires to IDLE, i.e. the cycle after the final write is accepted.
- done_out registered: done_out <= done_in & (state==IDLE) & ~in_valid. It deasserts the cycle after any of these terms becomes false.
- Address arithmetic is ADDR_W bits, truncating: addr+DEPTH_OFFSET wraps past 2^ADDR_W-1.
- Counters wrap from all-ones to 0.

Test Plan:
- Single pass: stored depth 32'h0005_0000, fragment addr=0x000010, depth=32'h0002_0000, color=24'hFF8040, zero wait states. Required: read at 0x100010; writes 32'h0002_0000 to 0x100010, then 32'h00FF8040 to 0x000010; frag_written=1; stall_out high 4 cycles.
- Reject: stored depth equals depth_in (32'h0001_0000). Required: no mem_write; frag_rejected=1; back in IDLE one cycle after readdatavalid.
- Waitrequest: mem_waitrequest held high 3 cycles on each request. Required: address and data held stable throughout, exactly one read and two writes retire, upstream fragment held with stall_out=1.
- Back-to-back: 3 fragments presented with in_valid continuously high. Required: each accepted only when stall_out=0, no fragment lost or duplicated; frag_written=3.
- Wrap and done: addr=26'h3FFFFF0 gives depth address 26'h00FFFF0. done_in raised with in_valid=0 while idle gives done_out=1 next cycle; raised mid-fragment, done_out=1 only after the color write retires.
- Reset mid-operation: assert reset during WR_DEPTH. Required: mem_write drops immediately, counters=0, stall_out=0; a following fragment processes normally.
